mem_delayed_pipelined: RTL and testbench
========================================

// Module: mem_delayed_pipelined
// PURPOSE
//   Simulated main memory with fixed access latency. Unlike the single-request delayed memory, it
//   accepts one new request per cycle, up to MAX_OUTSTANDING requests in flight, and completes them
//   in order. Writes take per-byte strobes. It sits between the core/LSU and backing storage and is
//   used to exercise latency-tolerant load/store paths.
// PARAMETERS
//   DATA_WIDTH       32    word width in bits; multiple of 8
//   ADDR_WIDTH       32    byte-address width
//   DEPTH_WORDS      4096  storage words; power of 2
//   DELAY            5     cycles from accept to ack; >= 1
//   MAX_OUTSTANDING  4     max in-flight requests; 1..DELAY
// PORTS
//   clk      in   1            clock, rising edge
//   rst      in   1            asynchronous reset, active-high
//   rd_req   in   1            read request
//   wr_req   in   1            write request
//   addr     in   ADDR_WIDTH   byte address
//   wr_data  in   DATA_WIDTH   write data
//   wr_strb  in   DATA_WIDTH/8 byte enables for write
//   busy     out  1            cannot accept a request this cycle
//   ack      out  1            one request completes this cycle
//   ack_wr   out  1            completing request was a write (valid with ack)
//   rd_data  out  DATA_WIDTH   read data (valid with ack & ~ack_wr)
// BEHAVIOUR
// - Addressing: word index = addr >> log2(DATA_WIDTH/8), modulo DEPTH_WORDS.
//   Low byte-offset bits are ignored, so 8 and 11 hit the same word and 12 hits the next word.
// - Accept: a request is accepted on a rising edge when (rd_req|wr_req) & ~busy.
//   - addr, wr_data and wr_strb are sampled at accept and need not be held afterwards.
//   - If rd_req and wr_req are both high, the write is accepted and the read is dropped.
// - busy = (outstanding == MAX_OUTSTANDING). It is decoded from registers only and has no
//   combinational path from the inputs.
// - Latency: a request accepted at edge N drives ack high for exactly one cycle after edge N+DELAY.
//   Back-to-back accepts give back-to-back acks in acceptance order.
// - Pipeline: a DELAY-stage shift register. Each stage holds {valid, is_wr, word index, data, strb}.
//   The final stage completes. A write updates only its strobed bytes at completion.
//   A read samples storage at completion into the registered rd_data.
// - Ordering: all requests have the same latency and complete in order. A read therefore sees every
//   write accepted before it, including a write to the same word accepted in the previous cycle.
// - rd_data holds its last read value when ack is low, and after a write ack.
// - Outstanding counter:
//   - +1 on accept, -1 on ack.
//   - Accept and ack on the same edge leave it unchanged.
//   - When full and the head completes on the same edge, busy drops in the next cycle, not the same one.
// - Reset (async, any time):
//   - Clears all stages and the counter. busy=0, ack=0, ack_wr=0, rd_data=0.
//   - In-flight writes are discarded and never applied.
//   - Storage contents are not reset.
// - Write with wr_strb==0 still occupies a slot and acks, but leaves storage unchanged.
// TESTING
// 1 Write 0x8<-0xab and 0x10<-0xcd, each strb all 1s, non-overlapped -> each ack exactly DELAY cycles after accept, ack_wr=1.
// 2 Reads of 0x10 then 0x8 issued on consecutive cycles -> acks on consecutive cycles with rd_data 0xcd then 0xab, ack_wr=0.
// 3 Write 8<-0xab, write 11<-0xcd, read 8, issued back-to-back -> read returns 0xcd. Write 12<-0x11, read 8 -> returns 0xcd.
// 4 Issue MAX_OUTSTANDING+2 reads on consecutive cycles -> busy rises after the MAX_OUTSTANDING-th accept.
//   Extra requests are held off, all complete in order, and there are never more than MAX_OUTSTANDING in flight.
// 5 Write 0x20<-0xffffffff, then write 0x20<-0x00000000 with wr_strb=4'b0010 -> read 0x20 returns 0xffff00ff.
// 6 Accept write 0x24<-0x55, assert rst 2 cycles later -> ack never rises and busy=0 immediately.
//   A later read of 0x24 returns the pre-write value.

Source files
------------

// File: rtl/mem_delayed_pipelined.sv
// mem_delayed_pipelined
//   Simulated main memory with a fixed access latency of DELAY cycles. It
//   accepts one request per cycle while fewer than MAX_OUTSTANDING are in
//   flight and completes them in acceptance order. Writes use per-byte strobes.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   rd_req   in   read request
//   wr_req   in   write request (wins over rd_req when both are high)
//   addr     in   byte address (the low byte-offset bits are ignored)
//   wr_data  in   write data
//   wr_strb  in   byte enables for write
//   busy     out  no request can be accepted this cycle (registered decode)
//   ack      out  one request completes this cycle
//   ack_wr   out  the completing request was a write
//   rd_data  out  read data, held between read completions
module mem_delayed_pipelined #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DEPTH_WORDS     = 4096,
  parameter int unsigned DELAY           = 5,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    busy,
  output logic                    ack,
  output logic                    ack_wr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Pipeline stages; index DELAY-1 is the head that completes.
  logic [DELAY-1:0]      st_v;
  logic [DELAY-1:0]      st_wr;
  logic [IDX_W-1:0]      st_idx  [DELAY];
  logic [DATA_WIDTH-1:0] st_data [DELAY];
  logic [STRB_W-1:0]     st_strb [DELAY];

  logic [CNT_W-1:0]      count;
  logic                  accept;
  logic                  head_v;
  logic                  head_wr;
  logic [IDX_W-1:0]      head_idx;

  assign accept   = (rd_req | wr_req) & ~busy;
  assign busy     = (count == CNT_W'(MAX_OUTSTANDING));
  assign head_v   = st_v[DELAY-1];
  assign head_wr  = st_wr[DELAY-1];
  assign head_idx = st_idx[DELAY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_v    <= '0;
      st_wr   <= '0;
      for (int unsigned i = 0; i < DELAY; i++) begin
        st_idx[i]  <= '0;
        st_data[i] <= '0;
        st_strb[i] <= '0;
      end
      count   <= '0;
      ack     <= 1'b0;
      ack_wr  <= 1'b0;
      rd_data <= '0;
    end else begin
      st_v[0]    <= accept;
      st_wr[0]   <= wr_req;
      // Truncating the shifted address gives the modulo-DEPTH word index.
      st_idx[0]  <= IDX_W'(addr >> OFF_W);
      st_data[0] <= wr_data;
      st_strb[0] <= wr_strb;
      for (int unsigned i = 1; i < DELAY; i++) begin
        st_v[i]    <= st_v[i-1];
        st_wr[i]   <= st_wr[i-1];
        st_idx[i]  <= st_idx[i-1];
        st_data[i] <= st_data[i-1];
        st_strb[i] <= st_strb[i-1];
      end

      ack    <= head_v;
      ack_wr <= head_v & head_wr;
      if (head_v && !head_wr) begin
        rd_data <= mem[head_idx];
      end

      if (accept && !head_v) begin
        count <= count + 1'b1;
      end else if (!accept && head_v) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is never reset; in-flight writes are dropped because reset
  // clears the stage valid bits that gate this write.
  always_ff @(posedge clk) begin
    if (head_v && head_wr) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (st_strb[DELAY-1][b]) begin
          mem[head_idx][b*8 +: 8] <= st_data[DELAY-1][b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_delayed_pipelined.sv
module tb_mem_delayed_pipelined;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned DEP  = 4096;
  localparam int unsigned DLY  = 5;
  localparam int unsigned MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          busy, ack, ack_wr;
  logic [DW-1:0] rd_data;

  mem_delayed_pipelined #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .DEPTH_WORDS     (DEP),
    .DELAY           (DLY),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .addr    (addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .busy    (busy),
    .ack     (ack),
    .ack_wr  (ack_wr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
    int unsigned due;   // value of cyc at the negedge where ack must be seen
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every ack, and checks busy against the
  // number of requests the model believes are in flight.
  always @(negedge clk) begin
    exp_t e;
    int   n;
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("ack_without_request", {31'd0, ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.due);
        chk("ack_wr", {31'd0, ack_wr}, {31'd0, e.is_wr});
        if (!e.is_wr) begin
          chk("rd_data", rd_data, e.data);
          last_rd = e.data;
        end else begin
          chk("rd_data_hold", rd_data, last_rd);
        end
      end
    end
    n = 0;
    foreach (sb[i]) if (sb[i].due <= cyc + DLY) n++;
    chk("busy", {31'd0, busy}, {31'd0, (n == int'(MAXO))});
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_d, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    rd_req = rd; wr_req = wr; addr = a; wr_data = d; wr_strb = s;
    while (busy && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (busy) begin
      chk("accept_timeout", {31'd0, busy}, 32'd0);
      return;
    end
    e.is_wr = wr;
    e.data  = exp_d;
    e.due   = cyc + 1 + DLY;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic drain();
    int t;
    idle();
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    int w;
    int w5, w6;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    addr = '0; wr_data = '0; wr_strb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy",    {31'd0, busy},   32'd0);
    chk("reset_ack",     {31'd0, ack},    32'd0);
    chk("reset_ack_wr",  {31'd0, ack_wr}, 32'd0);
    chk("reset_rd_data", rd_data,         32'd0);

    // Isolated writes
    issue(0, 1, 32'h8,  32'hab, 4'hf, 32'h0, w); drain();
    issue(0, 1, 32'h10, 32'hcd, 4'hf, 32'h0, w); drain();

    // Back-to-back reads
    issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hcd, w);
    issue(1, 0, 32'h8,  32'h0, 4'h0, 32'hab, w);
    drain();

    // Same-word aliasing and read-after-write ordering
    issue(0, 1, 32'h8,  32'hab, 4'hf, 32'h0, w);
    issue(0, 1, 32'hb,  32'hcd, 4'hf, 32'h0, w);
    issue(1, 0, 32'h8,  32'h0,  4'h0, 32'hcd, w);
    drain();
    issue(0, 1, 32'hc,  32'h11, 4'hf, 32'h0, w);
    issue(1, 0, 32'h8,  32'h0,  4'h0, 32'hcd, w);
    issue(1, 0, 32'hc,  32'h0,  4'h0, 32'h11, w);
    drain();

    // Saturate the in-flight limit
    issue(1, 0, 32'h8,  32'h0, 4'h0, 32'hcd, w);
    issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hcd, w);
    issue(1, 0, 32'hc,  32'h0, 4'h0, 32'h11, w);
    issue(1, 0, 32'h8,  32'h0, 4'h0, 32'hcd, w);
    issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hcd, w5);
    issue(1, 0, 32'hc,  32'h0, 4'h0, 32'h11, w6);
    drain();
    chk("held_off_cycles_5th", w5, 32'd2);
    chk("held_off_cycles_6th", w6, 32'd0);

    // Byte strobes, including an all-zero strobe
    issue(0, 1, 32'h20, 32'hffffffff, 4'hf, 32'h0, w);
    issue(0, 1, 32'h20, 32'h00000000, 4'h2, 32'h0, w);
    issue(1, 0, 32'h20, 32'h0,        4'h0, 32'hffff00ff, w);
    issue(0, 1, 32'h20, 32'h00000000, 4'h0, 32'h0, w);
    issue(1, 0, 32'h20, 32'h0,        4'h0, 32'hffff00ff, w);
    drain();

    // Read and write together: write wins
    issue(1, 1, 32'h30, 32'h77, 4'hf, 32'h0, w);
    issue(1, 0, 32'h30, 32'h0,  4'h0, 32'h77, w);
    drain();

    // Reset discards an in-flight write
    issue(0, 1, 32'h24, 32'h12345678, 4'hf, 32'h0, w);
    drain();
    issue(0, 1, 32'h24, 32'h55, 4'hf, 32'h0, w);
    idle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    last_rd = '0;
    #1;
    chk("async_reset_busy",    {31'd0, busy},   32'd0);
    chk("async_reset_ack",     {31'd0, ack},    32'd0);
    chk("async_reset_ack_wr",  {31'd0, ack_wr}, 32'd0);
    chk("async_reset_rd_data", rd_data,         32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(1, 0, 32'h24, 32'h0, 4'h0, 32'h12345678, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
